// File: rtl/sos_pkg.sv
// Shared types and constants for the SOS coefficient loader: coefficient order,
// framing byte, error causes and loader FSM states.
package sos_pkg;

  localparam int         NUM_COEF  = 5;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Order of the five coefficients inside one biquad section.
  typedef enum logic [2:0] {
    B0 = 3'd0,
    B1 = 3'd1,
    B2 = 3'd2,
    A1 = 3'd3,
    A2 = 3'd4
  } coef_idx_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CSUM    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_CHECK,
    ST_VERDICT
  } state_e;

  function automatic int bytes_per_coef(input int cof_wd);
    return (cof_wd + 7) / 8;
  endfunction

endpackage

// File: rtl/sos_coeff_bank.sv
// Shadow byte store plus the active coefficient bank; a commit strobe copies the
// whole shadow into the active bank in one cycle, reset restores pass-through.
module sos_coeff_bank
  import sos_pkg::*;
#(
  parameter int  COF_WD    = 32,
  parameter int  SHIFT_NUM = 30,
  parameter int  NUM_SEC   = 4,
  localparam int CB        = bytes_per_coef(COF_WD),
  localparam int NCOEF     = NUM_SEC * NUM_COEF,
  localparam int P         = NCOEF * CB,
  localparam int AW        = $clog2(P)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en_i,
  input  logic [AW-1:0]             wr_addr_i,
  input  logic [7:0]                wr_data_i,
  input  logic                      commit_i,
  output logic [NCOEF*COF_WD-1:0]   coef_o
);

  localparam logic [COF_WD-1:0] B0_UNITY = {{(COF_WD-1){1'b0}}, 1'b1} << SHIFT_NUM;

  function automatic logic [NCOEF*COF_WD-1:0] pass_through();
    logic [NCOEF*COF_WD-1:0] v;
    v = '0;
    for (int s = 0; s < NUM_SEC; s++) begin
      v[(s*NUM_COEF + int'(B0))*COF_WD +: COF_WD] = B0_UNITY;
    end
    return v;
  endfunction

  logic [7:0]              shadow_q [P];
  logic [NCOEF*COF_WD-1:0] shadow_flat;
  logic [CB*8-1:0]         word;
  logic [NCOEF*COF_WD-1:0] active_q;

  // NOTE: the shadow store is a small register array, so it is reset explicitly;
  // a RAM-style array without reset would leave stale bytes after a mid-frame reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < P; i++) shadow_q[i] <= '0;
    end else if (wr_en_i) begin
      shadow_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Reassemble little-endian bytes into coefficients; bits above COF_WD are dropped.
  always_comb begin
    shadow_flat = '0;
    word        = '0;
    for (int c = 0; c < NCOEF; c++) begin
      for (int b = 0; b < CB; b++) begin
        word[b*8 +: 8] = shadow_q[c*CB + b];
      end
      shadow_flat[c*COF_WD +: COF_WD] = word[COF_WD-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= pass_through();
    end else if (commit_i) begin
      active_q <= shadow_flat;
    end
  end

  assign coef_o = active_q;

endmodule

// File: rtl/sos_coeff_loader.sv
// Framed, checksummed byte-stream loader: parses sync/payload/checksum, times out
// stalled frames and commits the shadow bank atomically on a good checksum.
module sos_coeff_loader
  import sos_pkg::*;
#(
  parameter int COF_WD    = 32,
  parameter int SHIFT_NUM = 30,
  parameter int NUM_SEC   = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic                              abort,
  output logic [NUM_SEC*NUM_COEF*COF_WD-1:0] coef_o,
  output logic                              cfg_update,
  output logic                              frame_err,
  output logic [1:0]                        err_code,
  output logic                              busy
);

  localparam int CB    = bytes_per_coef(COF_WD);
  localparam int NCOEF = NUM_SEC * NUM_COEF;
  localparam int P     = NCOEF * CB;
  localparam int AW    = $clog2(P);
  localparam int TW    = $clog2(TIMEOUT + 1);

  state_e      state_q, state_d;
  logic [AW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        csum_ok_q, csum_ok_d;
  err_code_e   err_q, err_d;
  logic        cfg_update_q, cfg_update_d;
  logic        frame_err_q, frame_err_d;

  logic in_frame, abort_hit, accept, bank_wr, bank_commit;

  // An abort inside a frame also drops s_ready so the handshake never sees the byte taken.
  assign in_frame    = (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
  assign abort_hit   = abort && in_frame;
  assign s_ready     = (state_q != ST_VERDICT) && !abort_hit;
  assign accept      = s_valid && s_ready;
  assign bank_wr     = accept && (state_q == ST_PAYLOAD);
  assign bank_commit = (state_q == ST_VERDICT) && csum_ok_q;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    sum_d        = sum_q;
    tmo_d        = tmo_q;
    csum_ok_d    = csum_ok_q;
    err_d        = err_q;
    cfg_update_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (accept && (s_data == SYNC_BYTE)) begin
          state_d    = ST_PAYLOAD;
          byte_cnt_d = '0;
          sum_d      = '0;
        end
      end

      ST_PAYLOAD, ST_CHECK: begin
        if (abort_hit) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          tmo_d = '0;
          if (state_q == ST_PAYLOAD) begin
            sum_d      = sum_q + s_data;
            byte_cnt_d = byte_cnt_q + AW'(1);
            if (byte_cnt_q == AW'(P - 1)) state_d = ST_CHECK;
          end else begin
            csum_ok_d = (s_data == sum_q);
            state_d   = ST_VERDICT;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th consecutive cycle without a byte.
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
          err_d       = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_VERDICT: begin
        state_d = ST_IDLE;
        if (csum_ok_q) begin
          cfg_update_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
          err_d       = ERR_CSUM;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= '0;
      sum_q        <= '0;
      tmo_q        <= '0;
      csum_ok_q    <= 1'b0;
      err_q        <= ERR_NONE;
      cfg_update_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      sum_q        <= sum_d;
      tmo_q        <= tmo_d;
      csum_ok_q    <= csum_ok_d;
      err_q        <= err_d;
      cfg_update_q <= cfg_update_d;
      frame_err_q  <= frame_err_d;
    end
  end

  sos_coeff_bank #(
    .COF_WD    (COF_WD),
    .SHIFT_NUM (SHIFT_NUM),
    .NUM_SEC   (NUM_SEC)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (bank_wr),
    .wr_addr_i (byte_cnt_q),
    .wr_data_i (s_data),
    .commit_i  (bank_commit),
    .coef_o    (coef_o)
  );

  assign cfg_update = cfg_update_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sos_coeff_loader.sv
// Scoreboard bench: frame tasks push expected commit/error events, a negedge
// monitor pops and compares them whenever cfg_update or frame_err pulses.
module tb_sos_coeff_loader;

  localparam int COF_WD    = 32;
  localparam int SHIFT_NUM = 30;
  localparam int NUM_SEC   = 4;
  localparam int TIMEOUT   = 1024;
  localparam int NCOEF     = NUM_SEC * 5;
  localparam int CB        = 4;
  localparam int P         = NCOEF * CB;
  localparam int BW        = NCOEF * COF_WD;

  typedef logic [COF_WD-1:0] coef_arr_t [NCOEF];
  typedef struct {
    bit            is_commit;
    logic [1:0]    code;
    logic [BW-1:0] bank;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          abort;
  logic [BW-1:0] coef_o;
  logic          cfg_update;
  logic          frame_err;
  logic [1:0]    err_code;
  logic          busy;

  int            checks = 0;
  int            errors = 0;
  exp_t          exp_q[$];
  logic [BW-1:0] model_active;
  logic [1:0]    model_err;

  always #5 clk = ~clk;

  sos_coeff_loader #(
    .COF_WD(COF_WD), .SHIFT_NUM(SHIFT_NUM), .NUM_SEC(NUM_SEC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .abort(abort), .coef_o(coef_o), .cfg_update(cfg_update), .frame_err(frame_err),
    .err_code(err_code), .busy(busy)
  );

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack_bank(input coef_arr_t c);
    logic [BW-1:0] v;
    for (int k = 0; k < NCOEF; k++) v[k*COF_WD +: COF_WD] = c[k];
    return v;
  endfunction

  function automatic logic [BW-1:0] pass_bank();
    logic [BW-1:0] v;
    v = '0;
    for (int s = 0; s < NUM_SEC; s++) v[(s*5)*COF_WD +: COF_WD] = 32'h4000_0000;
    return v;
  endfunction

  function automatic coef_arr_t rand_coefs();
    coef_arr_t c;
    for (int k = 0; k < NCOEF; k++) c[k] = $urandom;
    return c;
  endfunction

  // Payload byte i = byte (i % CB) of coefficient (i / CB), LSB first.
  function automatic logic [7:0] payload_byte(input coef_arr_t c, input int i);
    logic [COF_WD-1:0] w;
    w = c[i / CB];
    return w[(i % CB)*8 +: 8];
  endfunction

  function automatic logic [7:0] payload_sum(input coef_arr_t c);
    int s;
    s = 0;
    for (int i = 0; i < P; i++) s += payload_byte(c, i);
    return 8'(s % 256);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    bit   done;
    done    = 0;
    s_data  = b;
    s_valid = 1'b1;
    for (int n = 0; n < 4 && !done; n++) begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      done = rdy;
    end
    s_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte %0h never accepted", b);
    end
  endtask

  task automatic idle_cycles(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_partial(input coef_arr_t c, input int nbytes);
    send_byte(8'hA5);
    for (int i = 0; i < nbytes; i++) send_byte(payload_byte(c, i));
  endtask

  task automatic send_frame(input coef_arr_t c, input bit corrupt, input int gap_max);
    logic [7:0] csum;
    send_byte(8'hA5);
    for (int i = 0; i < P; i++) begin
      if (gap_max > 0) idle_cycles($urandom_range(0, gap_max));
      send_byte(payload_byte(c, i));
    end
    csum = payload_sum(c) + (corrupt ? 8'd1 : 8'd0);
    if (corrupt) begin
      model_err = 2'b01;
      exp_q.push_back('{is_commit: 1'b0, code: model_err, bank: model_active});
    end else begin
      model_active = pack_bank(c);
      exp_q.push_back('{is_commit: 1'b1, code: model_err, bank: model_active});
    end
    send_byte(csum);
    check("verdict_bubble", s_ready, 1'b0);
    @(posedge clk);
    #1;
    check("ready_after_verdict", s_ready, 1'b1);
    check("cfg_update_at_e1", cfg_update, !corrupt);
    check("frame_err_at_e1", frame_err, corrupt);
    @(posedge clk);
    #1;
    check("pulse_one_cycle", {cfg_update, frame_err}, 2'b00);
  endtask

  // Monitor: every result pulse must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (cfg_update || frame_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: cfg_update=%0b frame_err=%0b with nothing expected",
                 cfg_update, frame_err);
      end else begin
        e = exp_q.pop_front();
        check("mon_cfg_update", cfg_update, e.is_commit);
        check("mon_frame_err", frame_err, !e.is_commit);
        check("mon_err_code", err_code, e.code);
        check("mon_coef_bank", coef_o, e.bank);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    coef_arr_t  c;
    coef_arr_t  c_plan;
    logic [7:0] junk;
    int         cyc;

    rst          = 1'b1;
    s_data       = '0;
    s_valid      = 1'b0;
    abort        = 1'b0;
    model_active = pass_bank();
    model_err    = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle_cycles(2);

    check("reset_coef", coef_o, pass_bank());
    check("reset_s_ready", s_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_err_code", err_code, 2'b00);
    check("reset_pulses", {cfg_update, frame_err}, 2'b00);

    // Directed frame: section 2 a1 = 0xFFFF8000, back-to-back bytes.
    c_plan     = rand_coefs();
    c_plan[13] = 32'hFFFF_8000;
    send_frame(c_plan, 1'b0, 0);
    check("sec2_a1", coef_o[13*COF_WD +: COF_WD], 32'hFFFF_8000);

    // Same frame with a bad checksum leaves the bank alone.
    send_frame(c_plan, 1'b1, 0);
    check("csum_err_code", err_code, 2'b01);
    check("bank_kept_after_err", coef_o, pack_bank(c_plan));

    // Junk before sync, 0xA5 bytes inside the payload.
    send_byte(8'h00);
    send_byte(8'h5A);
    check("junk_ignored_idle", busy, 1'b0);
    c    = rand_coefs();
    c[0] = 32'h00A5_A5A5;
    c[7] = 32'hA5A5_A5A5;
    send_frame(c, 1'b0, 0);
    check("err_code_held", err_code, 2'b01);

    // Stall after payload byte 17 until the timeout fires.
    c = rand_coefs();
    send_partial(c, 18);
    model_err = 2'b10;
    exp_q.push_back('{is_commit: 1'b0, code: model_err, bank: model_active});
    cyc = 0;
    for (int i = 1; i <= TIMEOUT + 50 && cyc == 0; i++) begin
      @(posedge clk);
      #1;
      if (frame_err) cyc = i;
    end
    check("timeout_cycle", cyc, TIMEOUT);
    check("timeout_busy", busy, 1'b0);
    check("timeout_err_code", err_code, 2'b10);
    idle_cycles(1);
    send_frame(rand_coefs(), 1'b0, 0);

    // Abort collides with payload byte 40.
    c = rand_coefs();
    send_partial(c, 40);
    s_data  = payload_byte(c, 40);
    s_valid = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    check("abort_not_ready", s_ready, 1'b0);
    @(posedge clk);
    #1;
    abort   = 1'b0;
    s_valid = 1'b0;
    check("abort_idle", busy, 1'b0);
    idle_cycles(2);
    check("abort_no_err", err_code, 2'b10);
    send_frame(rand_coefs(), 1'b0, 0);

    // Randomized frames with junk, gaps and occasional corrupt checksums.
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 3)) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h3C;
        send_byte(junk);
      end
      send_frame(rand_coefs(), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of a frame.
    send_partial(rand_coefs(), 10);
    #2 rst = 1'b1;
    #1;
    model_active = pass_bank();
    model_err    = 2'b00;
    check("rst_mid_frame_coef", coef_o, pass_bank());
    check("rst_mid_frame_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_err_code", err_code, 2'b00);
    idle_cycles(1);
    send_frame(rand_coefs(), 1'b0, 1);

    idle_cycles(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
